// File: rtl/upc_seq.sv
// ---------------------------------------------------------------------------
// upc_seq : microsequencer next-address unit
//
// Sits between the microcode ROM and the micro-program counter register.
// Each cycle it decodes the current microword's sequencing field and tells
// the upc register either to increment (load_incr = 0) or to load upc_next
// (load_incr = 1). Supports jump, conditional jump, call/return through a
// small return-address stack, wait-on-condition, halt/restart and a sticky
// fault state for stack overflow/underflow.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   upc        in   current micro-address (AW)
//   uop        in   sequencing opcode (3)
//   uaddr      in   jump/call target (AW)
//   csel       in   condition select (clog2(NCOND))
//   cond       in   condition flags (NCOND)
//   start      in   single-cycle pulse, leaves HALTED
//   load_incr  out  1 = load upc_next, 0 = increment
//   upc_next   out  address to load (AW)
//   halted     out  sequencer is in HALTED
//   fault      out  sequencer is in FAULT (sticky until reset)
//   sp         out  return-stack occupancy, 0..DEPTH
//
// Optional feature: define UPC_SEQ_WDOG_EN to enable a WAIT watchdog that
// forces FAULT after WDOG_CYCLES consecutive unsatisfied WAIT cycles.
// ---------------------------------------------------------------------------
module upc_seq #(
    parameter int  AW          = 5,
    parameter int  DEPTH       = 4,
    parameter int  NCOND       = 4,
    parameter int  WDOG_CYCLES = 255,
    localparam int CSW         = (NCOND > 1) ? $clog2(NCOND) : 1,
    localparam int SPW         = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [AW-1:0]  upc,
    input  logic [2:0]     uop,
    input  logic [AW-1:0]  uaddr,
    input  logic [CSW-1:0] csel,
    input  logic [NCOND-1:0] cond,
    input  logic           start,
    output logic           load_incr,
    output logic [AW-1:0]  upc_next,
    output logic           halted,
    output logic           fault,
    output logic [SPW-1:0] sp
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    localparam logic [2:0] OP_CONT    = 3'b000;
    localparam logic [2:0] OP_JMP     = 3'b001;
    localparam logic [2:0] OP_JCOND   = 3'b010;
    localparam logic [2:0] OP_CALL    = 3'b011;
    localparam logic [2:0] OP_RET     = 3'b100;
    localparam logic [2:0] OP_WAIT    = 3'b101;
    localparam logic [2:0] OP_HALT    = 3'b110;
    localparam logic [2:0] OP_RESTART = 3'b111;

    logic [1:0]     r_state;
    logic [1:0]     w_state_d;
    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_stack [DEPTH];

    logic           w_sel;
    logic           w_push;
    logic           w_pop;
    logic           w_sp_clr;
    logic           w_load;
    logic [AW-1:0]  w_next;
    logic [AW-1:0]  w_upc_inc;
    logic [AW-1:0]  w_top;
    logic           w_full;
    logic           w_empty;
    logic           w_wait_stall;
    logic           w_wdog_trip;

    assign w_upc_inc = upc + AW'(1);
    assign w_full    = (r_sp == SPW'(DEPTH));
    assign w_empty   = (r_sp == '0);
    // Only consumed by RET when the stack is non-empty.
    assign w_top     = r_stack[IW'(r_sp - SPW'(1))];

    // Selected condition; a csel beyond NCOND matches no flag and reads false.
    always_comb begin
        w_sel = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            if (csel == CSW'(i)) w_sel = cond[i];
        end
    end

    assign w_wait_stall = (r_state == ST_RUN) && (uop == OP_WAIT) && !w_sel;

`ifdef UPC_SEQ_WDOG_EN
    localparam int WDW = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;

    logic [WDW-1:0] r_wdog;

    // Trip on the edge where the count would reach WDOG_CYCLES.
    assign w_wdog_trip = w_wait_stall && (r_wdog == WDW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_wdog <= '0;
        else if (w_wait_stall) r_wdog <= r_wdog + WDW'(1);
        else                   r_wdog <= '0;
    end
`else
    logic w_unused_wdog;
    assign w_unused_wdog = (WDOG_CYCLES == 0);
    assign w_wdog_trip   = 1'b0;
`endif

    // Next-address decode and next-state selection.
    always_comb begin
        w_load    = 1'b1;
        w_next    = upc;
        w_state_d = r_state;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_sp_clr  = 1'b0;
        case (r_state)
            ST_RUN: begin
                case (uop)
                    OP_CONT: w_load = 1'b0;
                    OP_JMP:  w_next = uaddr;
                    OP_JCOND: begin
                        if (w_sel) w_next = uaddr;
                        else       w_load = 1'b0;
                    end
                    OP_CALL: begin
                        if (w_full) begin
                            w_state_d = ST_FAULT;
                        end else begin
                            w_next = uaddr;
                            w_push = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (w_empty) begin
                            w_state_d = ST_FAULT;
                        end else begin
                            w_next = w_top;
                            w_pop  = 1'b1;
                        end
                    end
                    OP_WAIT: begin
                        if (w_sel) w_load = 1'b0;
                    end
                    OP_HALT: w_state_d = ST_HALTED;
                    default: begin
                        w_next   = '0;
                        w_sp_clr = 1'b1;
                    end
                endcase
                if (w_wdog_trip) w_state_d = ST_FAULT;
            end
            ST_HALTED: begin
                if (start) begin
                    w_next    = w_upc_inc;
                    w_state_d = ST_RUN;
                end
            end
            default: ;
        endcase
        // The upc register resets to 0 on its own; steer it there as well.
        if (reset) begin
            w_load = 1'b1;
            w_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_sp    <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_sp_clr)    r_sp <= '0;
            else if (w_push) r_sp <= r_sp + SPW'(1);
            else if (w_pop)  r_sp <= r_sp - SPW'(1);
        end
    end

    // Stack contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_push) r_stack[r_sp[IW-1:0]] <= w_upc_inc;
    end

    assign load_incr = w_load;
    assign upc_next  = w_next;
    assign halted    = (r_state == ST_HALTED);
    assign fault     = (r_state == ST_FAULT);
    assign sp        = r_sp;

endmodule

// File: doc/upc_seq.md
Name: upc_seq

Overview:
- Microsequencer next-address unit. It drives the micro-program counter register's load_incr/upc_next inputs and reads back its upc output.
- Each cycle it decodes the current microword's sequencing field (uop, uaddr, csel) and makes one of two choices:
  - increment: load_incr=0
  - load a target: load_incr=1 with upc_next
- Supports jump, conditional branch, subroutine call/return through a return-address stack, wait-on-condition, and halt/restart.
- Sits between the microcode ROM output and the upc register.

Parameters:
- AW, 5, micro-address width. Must match the upc register width.
- DEPTH, 4, return-stack entries (1..8).
- NCOND, 4, number of condition inputs. csel width = clog2(NCOND).
- WDOG_CYCLES, 255, WAIT timeout in cycles. Used only when UPC_SEQ_WDOG_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- upc  in  AW  current micro-address from the upc register.
- uop  in  3  sequencing opcode of the current microword.
- uaddr  in  AW  branch/call target.
- csel  in  clog2(NCOND)  condition select.
- cond  in  NCOND  condition flags, sampled in the same cycle.
- start  in  1  single-cycle pulse; leaves HALTED.
- load_incr  out  1  1 = load upc_next; 0 = increment.
- upc_next  out  AW  address to load.
- halted  out  1  state == HALTED.
- fault  out  1  state == FAULT (sticky).
- sp  out  clog2(DEPTH)+1  stack occupancy, 0..DEPTH.

Behaviour:
- Reset: asynchronous, active-high; clock clk. State = RUN, sp = 0, stack contents don't-care, halted = 0, fault = 0.
- While reset is high: load_incr = 1, upc_next = 0 (the upc register resets to 0 independently).
- Outputs:
  - load_incr and upc_next are combinational from upc, uop, uaddr, cond, state and stack top. Zero-latency decode; the upc register adds the single register stage.
  - State, sp and stack update on the rising clk edge.
- RUN state, by uop:
  - 000 CONT: load_incr = 0.
  - 001 JMP: load uaddr.
  - 010 JCOND: if cond[csel], load uaddr; else load_incr = 0.
  - 011 CALL: push upc+1 (mod 2^AW, wraps 31 -> 0), load uaddr, sp++.
  - 100 RET: load stack top, sp--.
  - 101 WAIT: if cond[csel], load_incr = 0; else load upc (hold).
  - 110 HALT: load upc, next state = HALTED.
  - 111 RESTART: load 0, sp := 0.
- HALTED: load upc (hold) every cycle, uop ignored.
  - start = 1 -> load upc+1, next state = RUN.
  - start in RUN is ignored.
- FAULT: load upc (hold) every cycle. Exit only by reset. Entered on:
  - CALL with sp == DEPTH (overflow): no push, sp unchanged, hold upc.
  - RET with sp == 0 (underflow): sp unchanged, hold upc.
- No simultaneous push/pop is possible: one uop per cycle.
- Out-of-range csel (>= NCOND) reads as condition false.
- Reset mid-WAIT, mid-HALT or mid-FAULT returns to RUN with sp = 0 immediately, without waiting for a clock edge.

Optional Feature:
- UPC_SEQ_WDOG_EN defined:
  - 8-bit-or-wider wait counter increments each consecutive RUN cycle spent in an unsatisfied WAIT.
  - Cleared when the WAIT completes, or when any non-WAIT uop executes.
  - Reaching WDOG_CYCLES forces FAULT on that edge.
- Not defined: no counter; WAIT may hold indefinitely.

Test Plan:
- Reset then CONT with upc=0..3 -> load_incr = 0 each cycle; halted = 0, fault = 0, sp = 0.
- JCOND: uaddr=5'h14, csel=2.
  - cond=4'b0100 -> load_incr = 1, upc_next = 5'h14.
  - cond=4'b0000 -> load_incr = 0.
- CALL at upc=5'h06, uaddr=5'h18 -> upc_next = 5'h18, sp = 1; later RET -> upc_next = 5'h07, sp = 0.
- Nested CALLs: 4 nest, 5th CALL -> fault = 1 and upc held thereafter; RET at sp=0 after fresh reset -> fault = 1.
- HALT at upc=5'h0A -> upc_next = 5'h0A for 10 cycles with halted = 1; start pulse -> upc_next = 5'h0B, halted = 0.
- WAIT with cond false for 3 cycles, then true -> hold 5'h0C 3 cycles, then load_incr = 0.
  - With UPC_SEQ_WDOG_EN and WDOG_CYCLES=8: 8 false cycles -> fault = 1.
  - Assert reset mid-fault -> fault = 0, sp = 0.
